// File: rtl/dlfloat16_fpu_issue_ctrl.sv
// Issue controller for the DLFloat16 add/mul/sign-injection units: queues requests,
// drives the shared fu_* bus for the unit's fixed latency and returns tagged results.
module dlfloat16_fpu_issue_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LAT_ADD = 2,
  parameter int unsigned LAT_MUL = 3,
  parameter int unsigned LAT_SGN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [1:0]  req_sel,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [2:0]  req_tag,
  output logic [3:0]  fu_ena,
  output logic [1:0]  fu_sel,
  output logic [15:0] fu_in1,
  output logic [15:0] fu_in2,
  input  logic [15:0] fu_out,
  input  logic [4:0]  fu_exc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [4:0]  rsp_exc,
  output logic [2:0]  rsp_tag,
  output logic        busy,
  output logic [15:0] done_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_SGN = 4'b0101;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  tag;
  } req_t;

  req_t          mem [DEPTH];
  req_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop;

  state_t        state;
  logic [2:0]    cnt;
  logic [2:0]    tag_q;

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_SGN);
  endfunction

  function automatic logic [2:0] lat_of(input logic [3:0] op);
    logic [2:0] l;
    l = '0;
    case (op)
      OP_ADD:  l = 3'(LAT_ADD);
      OP_MUL:  l = 3'(LAT_MUL);
      OP_SGN:  l = 3'(LAT_SGN);
      default: l = '0;
    endcase
    return l;
  endfunction

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign full      = (count == CW'(DEPTH));
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: req_op, sel: req_sel, a: req_a, b: req_b, tag: req_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tag_q     <= '0;
      fu_ena    <= '0;
      fu_sel    <= '0;
      fu_in1    <= '0;
      fu_in2    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_exc   <= '0;
      rsp_tag   <= '0;
      done_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            if (is_legal(head.op)) begin
              fu_ena <= head.op;
              fu_sel <= head.sel;
              fu_in1 <= head.a;
              fu_in2 <= head.b;
              cnt    <= lat_of(head.op);
              tag_q  <= head.tag;
              state  <= EXEC;
            end else begin
              // Illegal code never reaches a unit; answer directly with invalid-op.
              rsp_data  <= '0;
              rsp_exc   <= 5'b10000;
              rsp_tag   <= head.tag;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_data  <= fu_out;
            rsp_exc   <= fu_exc;
            rsp_tag   <= tag_q;
            rsp_valid <= 1'b1;
            fu_ena    <= '0;
            fu_sel    <= '0;
            fu_in1    <= '0;
            fu_in2    <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat16_fpu_issue_ctrl.sv
// Directed bench for dlfloat16_fpu_issue_ctrl with a registered toy model of the
// add/mul/sign-injection units driving fu_out/fu_exc.
module tb_dlfloat16_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [1:0]  req_sel;
  logic [15:0] req_a, req_b;
  logic [2:0]  req_tag;
  logic [3:0]  fu_ena;
  logic [1:0]  fu_sel;
  logic [15:0] fu_in1, fu_in2;
  logic [15:0] fu_out;
  logic [4:0]  fu_exc;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [4:0]  rsp_exc;
  logic [2:0]  rsp_tag;
  logic        busy;
  logic [15:0] done_cnt;

  dlfloat16_fpu_issue_ctrl #(.DEPTH(4), .LAT_ADD(2), .LAT_MUL(3), .LAT_SGN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_sel(req_sel),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fu_ena(fu_ena), .fu_sel(fu_sel), .fu_in1(fu_in1), .fu_in2(fu_in2),
    .fu_out(fu_out), .fu_exc(fu_exc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_exc(rsp_exc), .rsp_tag(rsp_tag), .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Toy units: integer add (carry -> exc bit0), low-half multiply (high half nonzero
  // -> exc bit2), sign injection on bit 15. Output registered, zero when disabled.
  always @(posedge clk) begin
    logic [16:0] s;
    logic [31:0] p;
    s = {1'b0, fu_in1} + {1'b0, fu_in2};
    p = fu_in1 * fu_in2;
    case (fu_ena)
      4'b0001: begin fu_out <= s[15:0]; fu_exc <= {4'b0, s[16]}; end
      4'b0010: begin fu_out <= p[15:0]; fu_exc <= {2'b0, |p[31:16], 2'b0}; end
      4'b0101: begin
        case (fu_sel)
          2'b00:   fu_out <= {~fu_in1[15], fu_in1[14:0]};
          2'b01:   fu_out <= {fu_in2[15], fu_in1[14:0]};
          2'b10:   fu_out <= {~fu_in2[15], fu_in1[14:0]};
          default: fu_out <= {fu_in1[15] ^ fu_in2[15], fu_in1[14:0]};
        endcase
        fu_exc <= '0;
      end
      default: begin fu_out <= '0; fu_exc <= '0; end
    endcase
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  tag;
    logic [15:0] data;
    logic [4:0]  exc;
    int          lat;   // push edge to first sample with rsp_valid
    int          ena;   // cycles with fu_ena active
  } vec_t;

  vec_t        vecs [11];
  int          n, ena_cnt, bad, run, nresp, extra;
  int          runs [3];
  logic [2:0]  rtags [3];
  logic [15:0] rdata [3];
  logic [3:0]  b_op  [3];
  logic [1:0]  b_sel [3];
  logic [15:0] b_a   [3];
  logic [15:0] b_b   [3];
  int          pushed, acc_at_drop, hs_cyc, acc6_cyc, pop2_cyc, stable_bad;
  logic        will_accept, have_ref;
  logic [15:0] ref_data;
  logic [2:0]  ref_tag;
  logic [4:0]  ref_exc;

  initial begin
    vecs[0]  = '{4'b0101, 2'b00, 16'h3E00, 16'h0000, 3'd5, 16'hBE00, 5'b00000, 3, 2};
    vecs[1]  = '{4'b0001, 2'b00, 16'h1234, 16'h0F0F, 3'd0, 16'h2143, 5'b00000, 4, 3};
    vecs[2]  = '{4'b0001, 2'b00, 16'hFFFF, 16'h0002, 3'd6, 16'h0001, 5'b00001, 4, 3};
    vecs[3]  = '{4'b0010, 2'b00, 16'h0003, 16'h0005, 3'd1, 16'h000F, 5'b00000, 5, 4};
    vecs[4]  = '{4'b0010, 2'b00, 16'h0100, 16'h0100, 3'd2, 16'h0000, 5'b00100, 5, 4};
    vecs[5]  = '{4'b0101, 2'b01, 16'h3C00, 16'h8000, 3'd2, 16'hBC00, 5'b00000, 3, 2};
    vecs[6]  = '{4'b0101, 2'b10, 16'hBC00, 16'h8000, 3'd4, 16'h3C00, 5'b00000, 3, 2};
    vecs[7]  = '{4'b0101, 2'b11, 16'hBC00, 16'h0000, 3'd7, 16'hBC00, 5'b00000, 3, 2};
    vecs[8]  = '{4'b1111, 2'b11, 16'h1111, 16'h2222, 3'd3, 16'h0000, 5'b10000, 1, 0};
    vecs[9]  = '{4'b0000, 2'b01, 16'hAAAA, 16'h5555, 3'd7, 16'h0000, 5'b10000, 1, 0};
    vecs[10] = '{4'b0011, 2'b10, 16'h0001, 16'h0001, 3'd4, 16'h0000, 5'b10000, 1, 0};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_sel = '0; req_a = '0; req_b = '0;
    req_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset fu_ena", 32'(fu_ena), 0);
    chk("reset fu_bus", 32'({fu_sel, fu_in1, fu_in2} != '0), 0);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_fields", 32'({rsp_data, rsp_exc, rsp_tag} != '0), 0);
    chk("reset done_cnt", 32'(done_cnt), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset req_ready", 32'(req_ready), 1);
    rst_n = 1'b1;

    // Single operations from an idle controller.
    for (int i = 0; i < 11; i++) begin
      req_op = vecs[i].op; req_sel = vecs[i].sel; req_a = vecs[i].a; req_b = vecs[i].b;
      req_tag = vecs[i].tag; req_valid = 1'b1; rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0; ena_cnt = 0; bad = 0;
      do begin
        @(posedge clk); #1;
        n++;
        if (fu_ena != '0) begin
          ena_cnt++;
          if (fu_ena != vecs[i].op || fu_sel != vecs[i].sel ||
              fu_in1 != vecs[i].a || fu_in2 != vecs[i].b) bad++;
        end else if ({fu_sel, fu_in1, fu_in2} != '0) bad++;
      end while (!rsp_valid && n < 20);
      chk($sformatf("v%0d latency", i), 32'(n), 32'(vecs[i].lat));
      chk($sformatf("v%0d fu_ena cycles", i), 32'(ena_cnt), 32'(vecs[i].ena));
      chk($sformatf("v%0d fu bus content", i), 32'(bad), 0);
      chk($sformatf("v%0d rsp_data", i), 32'(rsp_data), 32'(vecs[i].data));
      chk($sformatf("v%0d rsp_exc", i), 32'(rsp_exc), 32'(vecs[i].exc));
      chk($sformatf("v%0d rsp_tag", i), 32'(rsp_tag), 32'(vecs[i].tag));
      @(posedge clk); #1;
      chk($sformatf("v%0d rsp_valid after handshake", i), 32'(rsp_valid), 0);
      chk($sformatf("v%0d done_cnt", i), 32'(done_cnt), 32'(i + 1));
      chk($sformatf("v%0d busy idle", i), 32'(busy), 0);
    end

    // Back-to-back ADD, MUL, SGNJ: pop-to-rsp 3, 4, 2 cycles, in order.
    b_op[0] = 4'b0001; b_sel[0] = 2'b00; b_a[0] = 16'h0001; b_b[0] = 16'h0002;
    b_op[1] = 4'b0010; b_sel[1] = 2'b00; b_a[1] = 16'h0004; b_b[1] = 16'h0003;
    b_op[2] = 4'b0101; b_sel[2] = 2'b01; b_a[2] = 16'h3C00; b_b[2] = 16'h8000;
    run = 0; nresp = 0; bad = 0;
    for (int cyc = 0; cyc < 60 && nresp < 3; cyc++) begin
      if (cyc < 3) begin
        req_op = b_op[cyc]; req_sel = b_sel[cyc]; req_a = b_a[cyc]; req_b = b_b[cyc];
        req_tag = 3'(cyc); req_valid = 1'b1;
      end else req_valid = 1'b0;
      @(posedge clk); #1;
      if (fu_ena != '0) run++;
      if (rsp_valid) begin
        runs[nresp] = run; rtags[nresp] = rsp_tag; rdata[nresp] = rsp_data;
        if (fu_ena != '0) bad++;
        nresp++; run = 0;
      end
    end
    req_valid = 1'b0;
    chk("b2b response count", 32'(nresp), 3);
    chk("b2b add latency", 32'(runs[0]), 3);
    chk("b2b mul latency", 32'(runs[1]), 4);
    chk("b2b sgnj latency", 32'(runs[2]), 2);
    chk("b2b tag order", 32'({rtags[0], rtags[1], rtags[2]}), 32'({3'd0, 3'd1, 3'd2}));
    chk("b2b add data", 32'(rdata[0]), 32'h0003);
    chk("b2b mul data", 32'(rdata[1]), 32'h000C);
    chk("b2b sgnj data", 32'(rdata[2]), 32'hBC00);
    chk("b2b fu_ena idle at rsp", 32'(bad), 0);
    @(posedge clk); #1;
    chk("b2b done_cnt", 32'(done_cnt), 14);

    // FIFO full under backpressure, then drain; response held stable while stalled.
    pushed = 0; acc_at_drop = -1; hs_cyc = -1; acc6_cyc = -1; pop2_cyc = -1;
    nresp = 0; stable_bad = 0; have_ref = 1'b0;
    for (int cyc = 0; cyc < 100 && !(nresp == 6 && pushed == 6); cyc++) begin
      rsp_ready = (cyc >= 12);
      if (pushed < 6) begin
        req_op = 4'b0101; req_sel = 2'b00; req_a = {8'(pushed + 1), 8'h00}; req_b = '0;
        req_tag = 3'(pushed); req_valid = 1'b1;
      end else req_valid = 1'b0;
      if (pushed < 6 && !req_ready && acc_at_drop < 0) acc_at_drop = pushed;
      will_accept = req_valid && req_ready;
      if (rsp_valid && rsp_ready) begin
        chk($sformatf("fifo rsp%0d tag", nresp), 32'(rsp_tag), 32'(nresp));
        chk($sformatf("fifo rsp%0d data", nresp), 32'(rsp_data),
            32'({8'(nresp + 1) | 8'h80, 8'h00}));
        if (nresp == 0) hs_cyc = cyc;
        nresp++;
      end else if (rsp_valid) begin
        if (!have_ref) begin
          ref_data = rsp_data; ref_tag = rsp_tag; ref_exc = rsp_exc; have_ref = 1'b1;
        end else if (rsp_data != ref_data || rsp_tag != ref_tag || rsp_exc != ref_exc)
          stable_bad++;
        if (fu_ena != '0) stable_bad++;
      end
      @(posedge clk); #1;
      if (will_accept) begin
        if (pushed == 5) acc6_cyc = cyc;
        pushed++;
      end
      if (hs_cyc >= 0 && pop2_cyc < 0 && fu_ena != '0) pop2_cyc = cyc;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid) extra++;
    end
    chk("fifo accepted before ready drop", 32'(acc_at_drop), 5);
    chk("fifo 6th accept cycle", 32'(acc6_cyc), 32'(hs_cyc + 2));
    chk("fifo pop after handshake", 32'(pop2_cyc), 32'(hs_cyc + 1));
    chk("fifo stall stability", 32'(stable_bad), 0);
    chk("fifo response count", 32'(nresp), 6);
    chk("fifo extra responses", 32'(extra), 0);
    chk("fifo done_cnt", 32'(done_cnt), 20);

    // Reset while MUL executes with two ops queued.
    for (int k = 0; k < 3; k++) begin
      req_op = (k == 0) ? 4'b0010 : 4'b0101; req_sel = 2'b00;
      req_a = 16'h0002; req_b = 16'h0003; req_tag = 3'(k + 1); req_valid = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("pre-reset fu_ena mul", 32'(fu_ena), 32'h2);
    chk("pre-reset busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset fu bus", 32'({fu_ena, fu_sel, fu_in1, fu_in2} != '0), 0);
    chk("async reset rsp", 32'({rsp_valid, rsp_data, rsp_exc, rsp_tag} != '0), 0);
    chk("async reset done_cnt", 32'(done_cnt), 0);
    chk("async reset busy", 32'(busy), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    extra = 0; bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rsp_valid) extra++;
      if (fu_ena != '0 || busy) bad++;
    end
    chk("post-reset no response", 32'(extra), 0);
    chk("post-reset idle", 32'(bad), 0);
    chk("post-reset done_cnt", 32'(done_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dlfloat16_fpu_issue_ctrl.md
Name: dlfloat16_fpu_issue_ctrl

Overview:
Issue controller for the DLFloat16 functional units: the add, mul and sign-injection units that share one operand/enable bus.
- Buffers incoming operation requests in a small FIFO.
- Decodes the unit code into the shared `fu_ena`/`fu_sel` bus and holds operands for the unit's fixed latency.
- Captures the result and exception flags, then returns them on a valid/ready response port with the requester's tag.
- Sits between the instruction front-end and the FPU datapath. `fu_ena` = 4'b0000 whenever no operation is in flight, so all units output zero.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >= 2)
LAT_ADD, 2, register stages of the add unit (1..7)
LAT_MUL, 3, register stages of the mul unit (1..7)
LAT_SGN, 1, register stages of the sign-injection unit (1..7)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  FIFO can accept; equals !full (combinational from FIFO count)
req_op  in  4  unit code: 4'b0001 ADD, 4'b0010 MUL, 4'b0101 SGNJ; all others illegal
req_sel  in  2  sub-operation passed to unit (SGNJ: 00 inv, 01 inj, 10 inj-inv, 11 xor)
req_a  in  16  operand 1
req_b  in  16  operand 2
req_tag  in  3  requester tag, returned unchanged
fu_ena  out  4  registered unit enable code
fu_sel  out  2  registered sub-operation
fu_in1  out  16  registered operand 1
fu_in2  out  16  registered operand 2
fu_out  in  16  unit result (registered inside unit)
fu_exc  in  5  unit exception flags
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts
rsp_data  out  16  result
rsp_exc  out  5  exceptions; bit4 = invalid-op
rsp_tag  out  3  tag of the operation
busy  out  1  state != IDLE or FIFO non-empty
done_cnt  out  16  completed-response count

Behaviour:
- Reset (async, rst_n low), all outputs and state cleared:
  - FIFO emptied; state = IDLE.
  - `fu_ena`, `fu_sel`, `fu_in1`, `fu_in2` = 0.
  - `rsp_valid`, `rsp_data`, `rsp_exc`, `rsp_tag` = 0; `done_cnt` = 0; `busy` = 0.
  - Reset mid-operation discards the in-flight op and all queued ops; no response is produced.
- FIFO:
  - Push on `req_valid && req_ready`.
  - When full, `req_ready` = 0 and the push is refused, even if a pop occurs in the same cycle.
  - Pop only in IDLE. Push and pop in the same cycle is allowed when not full; count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, RESP.
- IDLE with FIFO non-empty, at edge E0, pop the head entry:
  - Legal op: `fu_ena` <= op, `fu_sel` <= sel, `fu_in1` <= a, `fu_in2` <= b; 3-bit counter cnt <= LAT(op); tag latched; state <= EXEC.
  - Illegal op: no unit issue (`fu_ena` stays 0). `rsp_data` <= 0, `rsp_exc` <= 5'b10000, `rsp_tag` <= tag, `rsp_valid` <= 1; state <= RESP. `rsp_valid` is high after E0.
- EXEC:
  - `fu_*` held constant; cnt decrements each edge while cnt != 0.
  - At the edge where cnt == 0: `rsp_data` <= `fu_out`, `rsp_exc` <= `fu_exc`, `rsp_tag` <= latched tag, `rsp_valid` <= 1; `fu_ena`/`fu_sel`/`fu_in1`/`fu_in2` <= 0; state <= RESP.
  - EXEC therefore lasts LAT+1 cycles; `rsp_valid` rises at edge E(LAT+1) after the pop edge E0.
- RESP:
  - `rsp_*` stable while `rsp_valid && !rsp_ready`.
  - On handshake: `rsp_valid` <= 0, `done_cnt` <= `done_cnt` + 1 (wraps FFFF->0000), state <= IDLE.
  - The next pop occurs in the following cycle, so a legal op completes every LAT+3 cycles with `rsp_ready` held high.
- Only one op is in flight at a time; responses are returned in request order.
- `busy` is combinational from state and FIFO count.

Test Plan:
1. SGNJ: push op=0101, sel=00, a=16'h3E00, b=0, tag=5 with rsp_ready=1 -> `fu_ena`=0101 for exactly 2 cycles; `rsp_valid` rises 2 cycles after the pop edge; `rsp_data` = unit output (16'hBE00 with a sign-inj model), `rsp_exc`=0, `rsp_tag`=5; `done_cnt`=1.
2. Latency per unit: issue ADD, MUL, SGNJ back-to-back with rsp_ready=1 -> pop-to-`rsp_valid` = 3, 4, 2 cycles; responses in order with tags 0, 1, 2; `fu_ena` returns to 0000 between ops.
3. FIFO full: hold rsp_ready=0 and push 6 ops -> `req_ready` drops after DEPTH+1 accepted (one in flight plus 4 queued); 6th held off until the first response handshake; no entry lost or duplicated.
4. Illegal op 4'b1111, tag=3 -> `fu_ena` never leaves 0000; `rsp_valid` 1 cycle after pop; `rsp_data`=0, `rsp_exc`=5'b10000, `rsp_tag`=3.
5. Backpressure: rsp_ready=0 for 5 cycles during RESP -> `rsp_data`/`rsp_exc`/`rsp_tag` stable, no new pop; on handshake the next op pops the following cycle.
6. Reset mid-EXEC of MUL with 2 ops queued -> all outputs 0 immediately; after release, `busy`=0, no response appears, `done_cnt`=0.
